// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a length-prefixed byte stream,
// writes big-endian words to IMEM, verifies an XOR checksum, then releases the core.
module imem_loader #(
  parameter int SIZE = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        core_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  state_t      state_q;
  logic [7:0]  len_hi_q;
  logic [15:0] n_q;
  logic [15:0] k_q;
  logic [1:0]  cnt_q;
  logic [31:0] asm_q;
  logic [7:0]  xor_q;
  logic        wr_en_q;
  logic [31:0] wr_addr_q;
  logic [31:0] wr_data_q;

  logic        take;
  logic [15:0] len_d;
  logic [31:0] word_d;
  logic [7:0]  xor_d;

  assign byte_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                      (state_q == DATA)   || (state_q == CHECK);
  assign take   = byte_valid && byte_ready;
  assign len_d  = {len_hi_q, byte_data};
  assign word_d = {asm_q[23:0], byte_data};
  assign xor_d  = xor_q ^ byte_data;

  // Write strobe is a one-cycle registered pulse following the 4th byte of a word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= LEN_HI;
      len_hi_q  <= 8'h00;
      n_q       <= 16'h0000;
      k_q       <= 16'h0000;
      cnt_q     <= 2'd0;
      asm_q     <= 32'h0;
      xor_q     <= 8'h00;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 32'h0;
      wr_data_q <= 32'h0;
    end else begin
      wr_en_q <= 1'b0;
      if (take) begin
        case (state_q)
          LEN_HI: begin
            len_hi_q <= byte_data;
            state_q  <= LEN_LO;
          end
          LEN_LO: begin
            n_q <= len_d;
            if ({16'h0000, len_d} > 32'(SIZE)) state_q <= ERROR;
            else if (len_d == 16'h0000)        state_q <= CHECK;
            else                               state_q <= DATA;
          end
          DATA: begin
            asm_q <= word_d;
            xor_q <= xor_d;
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              wr_en_q   <= 1'b1;
              wr_data_q <= word_d;
              wr_addr_q <= {14'b0, k_q, 2'b00};
              k_q       <= k_q + 16'd1;
              if (k_q == n_q - 16'd1) state_q <= CHECK;
            end
          end
          CHECK: begin
            state_q <= (byte_data == xor_q) ? DONE : ERROR;
          end
          default: ;
        endcase
      end
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign done      = (state_q == DONE);
  assign error     = (state_q == ERROR);
  assign core_hold = (state_q != DONE);

endmodule
